// File: rtl/axi_or_tracker_pkg.sv
// Shared helpers for the AXI outstanding-request tracker.
package axi_or_tracker_pkg;

    function automatic int cnt_width(input int max_or);
        return $clog2(max_or + 1);
    endfunction

endpackage

// File: rtl/axi_or_counter.sv
// Saturating up/down counter of outstanding requests; holds at 0 and at MAX instead of wrapping.
module axi_or_counter
    import axi_or_tracker_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        srst,
    input  logic                        inc,
    input  logic                        dec,
    output logic [cnt_width(MAX)-1:0]   cnt,
    output logic                        nonzero
);

    localparam int CNT_W = cnt_width(MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A simultaneous request and completion cancel out; srst beats any event in its cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (srst) begin
            cnt_d = '0;
        end else if (inc && !dec && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/axi_or_tracker.sv
// Outstanding-request tracker for an AXI4 master port (pure monitor, one counter per direction).
// Optional event trace enabled by defining AXI_OR_TRACKER_TRACE_EN.
module axi_or_tracker
    import axi_or_tracker_pkg::*;
#(
    parameter     NAME   = "or_tracker",
    parameter int MAX_OR = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic srst,
    input  logic awvalid,
    input  logic awready,
    input  logic bvalid,
    input  logic bready,
    input  logic arvalid,
    input  logic arready,
    input  logic rvalid,
    input  logic rready,
    output logic waiting_wr_cpl,
    output logic waiting_rd_cpl
);

    localparam int CNT_W = cnt_width(MAX_OR);

    logic             aw_hs;
    logic             b_hs;
    logic             ar_hs;
    logic             r_hs;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             wr_nonzero;
    logic             rd_nonzero;

    assign aw_hs = awvalid & awready;
    assign b_hs  = bvalid & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    axi_or_counter #(.MAX(MAX_OR)) u_wr_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .inc     (aw_hs),
        .dec     (b_hs),
        .cnt     (wr_cnt),
        .nonzero (wr_nonzero)
    );

    // Every R beat is a completion: the master only issues single-beat reads.
    axi_or_counter #(.MAX(MAX_OR)) u_rd_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .inc     (ar_hs),
        .dec     (r_hs),
        .cnt     (rd_cnt),
        .nonzero (rd_nonzero)
    );

    assign waiting_wr_cpl = wr_nonzero;
    assign waiting_rd_cpl = rd_nonzero;

`ifdef AXI_OR_TRACKER_TRACE_EN
    function automatic int next_cnt(input int c, input logic i, input logic d);
        if (i && !d && c < MAX_OR) return c + 1;
        if (d && !i && c > 0)      return c - 1;
        return c;
    endfunction

    always @(posedge aclk) begin
        if (aresetn && !srst && (aw_hs || b_hs || ar_hs || r_hs)) begin
            $display("trace_%s: %0t %s%s%s%s wr_cnt=%0d rd_cnt=%0d", NAME, $realtime,
                     aw_hs ? "aw " : "", b_hs ? "b " : "", ar_hs ? "ar " : "", r_hs ? "r " : "",
                     next_cnt(int'(wr_cnt), aw_hs, b_hs), next_cnt(int'(rd_cnt), ar_hs, r_hs));
            if (aw_hs && !b_hs && int'(wr_cnt) == MAX_OR)
                $display("trace_%s: ERROR %0t write counter saturated at %0d", NAME, $realtime, MAX_OR);
            if (b_hs && !aw_hs && wr_cnt == '0)
                $display("trace_%s: ERROR %0t write completion with nothing outstanding", NAME, $realtime);
            if (ar_hs && !r_hs && int'(rd_cnt) == MAX_OR)
                $display("trace_%s: ERROR %0t read counter saturated at %0d", NAME, $realtime, MAX_OR);
            if (r_hs && !ar_hs && rd_cnt == '0)
                $display("trace_%s: ERROR %0t read completion with nothing outstanding", NAME, $realtime);
        end
    end
`else
    // The counts and the instance name only feed the trace.
    localparam int unused_name_w = $bits(NAME);
    logic unused_cnt;
    assign unused_cnt = ^{wr_cnt, rd_cnt};
`endif

endmodule

// File: tb/tb_axi_or_tracker.sv
// Randomized and directed bench for axi_or_tracker against an integer reference model.
module tb_axi_or_tracker;

    localparam int MAX_OR = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic srst = 1'b0;
    logic awvalid = 1'b0, awready = 1'b0, bvalid = 1'b0, bready = 1'b0;
    logic arvalid = 1'b0, arready = 1'b0, rvalid = 1'b0, rready = 1'b0;
    logic waiting_wr_cpl, waiting_rd_cpl;

    int checks = 0;
    int failures = 0;
    int wr_m = 0;
    int rd_m = 0;

    axi_or_tracker #(.NAME("or_tracker"), .MAX_OR(MAX_OR)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .srst           (srst),
        .awvalid        (awvalid),
        .awready        (awready),
        .bvalid         (bvalid),
        .bready         (bready),
        .arvalid        (arvalid),
        .arready        (arready),
        .rvalid         (rvalid),
        .rready         (rready),
        .waiting_wr_cpl (waiting_wr_cpl),
        .waiting_rd_cpl (waiting_rd_cpl)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (wr_model=%0d rd_model=%0d) at %0t",
                     tag, obs, exp, wr_m, rd_m, $time);
        end
    endtask

    // A handshake needs both valid and ready; otherwise pick a random non-handshake pair.
    task automatic pair(input bit hs, output logic v, output logic r);
        int k;
        if (hs) begin
            v = 1'b1; r = 1'b1;
        end else begin
            k = $urandom_range(0, 2);
            v = (k == 1); r = (k == 2);
        end
    endtask

    function automatic int model_step(input int c, input bit inc, input bit dec);
        int n;
        n = c + (inc ? 1 : 0) - (dec ? 1 : 0);
        if (n > MAX_OR) n = MAX_OR;
        if (n < 0) n = 0;
        return n;
    endfunction

    // Called just after a negedge: drive, take one rising edge, check at the next falling edge.
    task automatic cycle(input bit aw, input bit b, input bit ar, input bit r,
                         input bit s, input string tag);
        pair(aw, awvalid, awready);
        pair(b,  bvalid,  bready);
        pair(ar, arvalid, arready);
        pair(r,  rvalid,  rready);
        srst = s;
        @(posedge aclk);
        if (s) begin
            wr_m = 0; rd_m = 0;
        end else begin
            wr_m = model_step(wr_m, aw, b);
            rd_m = model_step(rd_m, ar, r);
        end
        @(negedge aclk);
        check({tag, ".wr"}, waiting_wr_cpl, wr_m != 0);
        check({tag, ".rd"}, waiting_rd_cpl, rd_m != 0);
    endtask

    initial begin
        // Held in reset while random handshakes toggle.
        for (int i = 0; i < 5; i++) begin
            pair($urandom_range(0, 1) == 1, awvalid, awready);
            pair($urandom_range(0, 1) == 1, bvalid, bready);
            pair($urandom_range(0, 1) == 1, arvalid, arready);
            pair($urandom_range(0, 1) == 1, rvalid, rready);
            @(negedge aclk);
            check("in_reset.wr", waiting_wr_cpl, 1'b0);
            check("in_reset.rd", waiting_rd_cpl, 1'b0);
        end
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, "idle");

        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, "aw3");
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, "b3");
        check("b3_drained", waiting_wr_cpl, 1'b0);

        cycle(1, 0, 0, 0, 0, "cnt1");
        cycle(1, 1, 0, 0, 0, "aw_b_same");
        check("aw_b_same_high", waiting_wr_cpl, 1'b1);
        cycle(0, 1, 0, 0, 0, "cnt1_drain");

        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, "ar5");
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, "r4");
        check("sat_still_one", waiting_rd_cpl, 1'b1);
        cycle(0, 0, 0, 1, 0, "r4_last");
        check("sat_back_zero", waiting_rd_cpl, 1'b0);
        cycle(0, 1, 0, 1, 0, "underflow");

        for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, 0, "pre_srst");
        cycle(1, 0, 1, 0, 1, "srst");
        cycle(0, 1, 0, 0, 0, "post_srst_b");
        check("post_srst_floor", waiting_wr_cpl, 1'b0);

        cycle(1, 0, 1, 0, 0, "inter_req");
        cycle(0, 0, 0, 1, 0, "inter_r");
        check("inter_wr_high", waiting_wr_cpl, 1'b1);
        check("inter_rd_low", waiting_rd_cpl, 1'b0);
        cycle(0, 1, 0, 0, 0, "inter_b");

        // Asynchronous reset in mid-cycle clears immediately.
        for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, 0, "pre_arst");
        #2 aresetn = 1'b0;
        #1;
        wr_m = 0; rd_m = 0;
        check("arst_now.wr", waiting_wr_cpl, 1'b0);
        check("arst_now.rd", waiting_rd_cpl, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        cycle(0, 1, 0, 1, 0, "post_arst_cpl");

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 2, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
